// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller.
// Owns the fetch PC, drives the instruction memory address, and buffers returned
// words in a small pointer-ring prefetch queue presented to decode over valid/ready.
// A redirect from execute flushes the queue and restarts fetch at the target.

module imem_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        run_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
    localparam logic [31:0]     NopInst = 32'h0000_0013;

    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [31:0]     pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic pop;
    logic fetch;

    // Redirect targets are word aligned; the low bits are deliberately ignored.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

    // Ring pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrLast) ? '0 : p + 1'b1;
    endfunction

    // Handshake and fetch qualification.
    always_comb begin
        pop   = out_valid_o & out_ready_i;
        // A pop in the same cycle frees a slot, so a full queue still streams.
        fetch = run_i & ~redirect_valid_i & ((count_q < CntFull) | pop);
    end

    // Next-state for PC, pointers and occupancy; redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (redirect_valid_i) begin
            // Any same-cycle pop is accepted by decode and then discarded by the flush.
            fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (fetch) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (fetch && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !fetch) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Queue storage: the fetched word is captured at the write pointer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= NopInst;
            end
        end else if (fetch) begin
            pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
            inst_mem_q[wr_ptr_q] <= imem_data_i;
        end
    end

    // Outputs come straight from registers; empty queue presents NOP at PC 0.
    always_comb begin
        imem_addr_o = fetch_pc_q;
        out_valid_o = (count_q != '0);
        out_inst_o  = NopInst;
        out_pc_o    = '0;
        if (out_valid_o) begin
            out_inst_o = inst_mem_q[rd_ptr_q];
            out_pc_o   = pc_mem_q[rd_ptr_q];
        end
    end

endmodule
